// File: rtl/i2s_src_fifo.sv
// I2S slave transmitter: buffers samples in a FIFO and shifts them out on DIN, all in HCLK.
// Optional macro I2S_SRC_FIFO_RAMP_EN sends per-channel ramp words instead of zeros on underrun.
module i2s_src_fifo #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MONO       = 0
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        en,
    input  logic                        BCLK,
    input  logic                        WS,
    output logic                        DIN,
    input  logic [SAMPLE_W-1:0]         s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    input  logic                        clr_underrun
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(SLOT_W + 1);
    localparam logic [AW:0]   LevelFull = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CntMax    = CW'(SLOT_W);

    logic [2:0]          bclk_sync_q;
    logic [1:0]          ws_sync_q;
    logic                ws_r_q, ws_p_q;
    logic                armed_q;
    logic                din_q;
    logic [SAMPLE_W-1:0] shift_q;
    logic [CW-1:0]       cnt_q;
    logic [SAMPLE_W-1:0] held_q;
    logic [AW:0]         wptr_q, rptr_q;
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic                underrun_q;

    logic                bclk_rise, bclk_fall, slot_start, slot_left, slot_tx;
    logic                need_pop, fifo_empty, pop, und_set, push;
    logic [SAMPLE_W-1:0] slot_word, fill_word;

`ifdef I2S_SRC_FIFO_RAMP_EN
    logic [SAMPLE_W-1:0] ramp_l_q, ramp_r_q;
    assign fill_word = slot_left ? ramp_l_q : ramp_r_q;
`else
    assign fill_word = '0;
`endif

    assign fifo_level = wptr_q - rptr_q;
    assign s_ready    = (fifo_level != LevelFull);
    assign DIN        = din_q;
    assign underrun   = underrun_q;

    always_comb begin
        bclk_rise  = bclk_sync_q[1] & ~bclk_sync_q[2];
        bclk_fall  = ~bclk_sync_q[1] & bclk_sync_q[2];
        slot_start = bclk_fall && (ws_r_q != ws_p_q);
        slot_left  = ~ws_r_q;
        // Right slots before the first left slot after enable are sent as silence.
        slot_tx    = en && (armed_q || slot_left);
        need_pop   = slot_start && slot_tx && (slot_left || (MONO == 0));
        fifo_empty = (wptr_q == rptr_q);
        pop        = need_pop && !fifo_empty;
        und_set    = need_pop && fifo_empty;
        push       = s_valid && s_ready;
        slot_word  = '0;
        if (slot_tx) begin
            if ((MONO != 0) && !slot_left) begin
                slot_word = held_q;
            end else if (!fifo_empty) begin
                slot_word = mem[rptr_q[AW-1:0]];
            end else begin
                slot_word = fill_word;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bclk_sync_q <= '0;
            ws_sync_q   <= '0;
            ws_r_q      <= 1'b0;
            ws_p_q      <= 1'b0;
            armed_q     <= 1'b0;
            din_q       <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            held_q      <= '0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[1:0], BCLK};
            ws_sync_q   <= {ws_sync_q[0], WS};
            if (bclk_rise) begin
                ws_r_q <= ws_sync_q[1];
            end
            if (slot_start) begin
                ws_p_q <= ws_r_q;
            end
            if (!en) begin
                armed_q <= 1'b0;
                din_q   <= 1'b0;
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (slot_start) begin
                din_q   <= slot_word[SAMPLE_W-1];
                shift_q <= slot_word << 1;
                cnt_q   <= CW'(1);
                if (slot_left) begin
                    armed_q <= 1'b1;
                    held_q  <= slot_word;
                end
            end else if (bclk_fall) begin
                din_q   <= (cnt_q < CntMax) & shift_q[SAMPLE_W-1];
                shift_q <= shift_q << 1;
                if (cnt_q < CntMax) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            underrun_q <= 1'b0;
`ifdef I2S_SRC_FIFO_RAMP_EN
            ramp_l_q   <= '0;
            ramp_r_q   <= '0;
`endif
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (clr_underrun) begin
                underrun_q <= 1'b0;
            end else if (und_set) begin
                underrun_q <= 1'b1;
            end
`ifdef I2S_SRC_FIFO_RAMP_EN
            if (und_set && slot_left) begin
                ramp_l_q <= ramp_l_q + 1'b1;
            end
            if (und_set && !slot_left) begin
                ramp_r_q <= ramp_r_q - 1'b1;
            end
`endif
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= s_data;
        end
    end

endmodule

// File: tb/tb_i2s_src_fifo.sv
// Bench for i2s_src_fifo: a stereo and a mono instance share BCLK/WS; an I2S receiver
// model rebuilds each slot from DIN and compares it with words predicted from a sample queue.
`timescale 1ns/1ps
module tb_i2s_src_fifo;
    localparam int SW    = 16;
    localparam int SL    = 32;
    localparam int DEPTH = 8;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic BCLK = 1'b0;
    logic WS = 1'b0;
    logic [1:0]       en = '0, s_valid = '0, clr = '0;
    logic [1:0][15:0] s_data = '0;
    logic [1:0]       din, rdy, und;
    logic [1:0][3:0]  lvl;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    i2s_src_fifo #(.SAMPLE_W(SW), .SLOT_W(SL), .FIFO_DEPTH(DEPTH), .MONO(0)) u_stereo (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en[0]), .BCLK(BCLK), .WS(WS), .DIN(din[0]),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(rdy[0]), .fifo_level(lvl[0]),
        .underrun(und[0]), .clr_underrun(clr[0])
    );

    i2s_src_fifo #(.SAMPLE_W(SW), .SLOT_W(SL), .FIFO_DEPTH(DEPTH), .MONO(1)) u_mono (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en[1]), .BCLK(BCLK), .WS(WS), .DIN(din[1]),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(rdy[1]), .fifo_level(lvl[1]),
        .underrun(und[1]), .clr_underrun(clr[1])
    );

    // Reference model state
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic        armed_m [2];
    logic        und_m   [2];
    logic [15:0] held_m  [2];
    logic [15:0] ramp_l  [2];
    logic [15:0] ramp_r  [2];
    logic [15:0] exp_word[2];
    // Receiver state
    logic        rx_ws   [2];
    logic        rx_live [2];
    logic        pend    [2];
    int          rx_n    [2];
    logic [31:0] rx_bits [2];

    typedef struct {
        logic [15:0] data;
        logic        exp_ready;
        logic [3:0]  exp_level;
    } fill_vec_t;
    fill_vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int m, input logic [15:0] d);
        if (m == 0) q0.push_back(d);
        else q1.push_back(d);
    endtask

    task automatic qpop(input int m, output logic [15:0] d);
        if (m == 0) d = q0.pop_front();
        else d = q1.pop_front();
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int m = 0; m < 2; m++) begin
            armed_m[m] = 1'b0; und_m[m] = 1'b0; held_m[m] = '0;
            ramp_l[m] = '0; ramp_r[m] = '0; exp_word[m] = '0;
            rx_ws[m] = 1'b0; rx_live[m] = 1'b0; pend[m] = 1'b0; rx_n[m] = 0; rx_bits[m] = '0;
        end
    endtask

    // Word the SoC should receive for a slot that starts now on channel ws_new.
    task automatic slot_model(input int m, input logic ws_new);
        logic [15:0] w;
        logic left;
        w = '0;
        left = !ws_new;
        if (!en[m]) begin
            armed_m[m] = 1'b0;
        end else if (left || armed_m[m]) begin
            armed_m[m] = 1'b1;
            if (m == 1 && !left) begin
                w = held_m[m];
            end else if (qsize(m) > 0) begin
                qpop(m, w);
            end else begin
                und_m[m] = 1'b1;
`ifdef I2S_SRC_FIFO_RAMP_EN
                if (left) begin
                    w = ramp_l[m];
                    ramp_l[m] = ramp_l[m] + 16'd1;
                end else begin
                    w = ramp_r[m];
                    ramp_r[m] = ramp_r[m] - 16'd1;
                end
`endif
            end
            if (left) held_m[m] = w;
        end
        exp_word[m] = w;
    endtask

    task automatic rx_rise(input int m, input logic ws_v, input logic d);
        rx_bits[m] = {rx_bits[m][30:0], d};
        rx_n[m]++;
        if (ws_v != rx_ws[m]) begin
            if (rx_live[m] && rx_n[m] == SL)
                check($sformatf("tail%0d", m), rx_bits[m][SL-SW-1:0], 0);
            rx_ws[m] = ws_v;
            pend[m] = 1'b1;
            rx_live[m] = 1'b1;
            rx_n[m] = 0;
            rx_bits[m] = '0;
        end else begin
            if (rx_n[m] == 1) begin
                check($sformatf("level%0d", m), lvl[m], qsize(m));
                check($sformatf("underrun%0d", m), und[m], und_m[m]);
            end
            if (rx_live[m] && rx_n[m] == SW)
                check($sformatf("word%0d_ws%0d", m, ws_v), rx_bits[m][15:0], exp_word[m]);
        end
    endtask

    // One BCLK period of 8 HCLK; WS changes on the falling edge, SoC samples on the rise.
    task automatic bclk_bit(input logic ws_v);
        @(negedge HCLK);
        BCLK = 1'b0;
        WS = ws_v;
        for (int m = 0; m < 2; m++) begin
            if (pend[m]) begin
                pend[m] = 1'b0;
                slot_model(m, rx_ws[m]);
            end
        end
        repeat (4) @(negedge HCLK);
        BCLK = 1'b1;
        for (int m = 0; m < 2; m++) rx_rise(m, ws_v, din[m]);
        repeat (3) @(negedge HCLK);
    endtask

    task automatic run_slot(input logic ws_v);
        repeat (SL) bclk_bit(ws_v);
    endtask

    task automatic push(input int m, input logic [15:0] d);
        @(negedge HCLK);
        check($sformatf("ready%0d", m), rdy[m], qsize(m) < DEPTH);
        s_valid[m] = 1'b1;
        s_data[m] = d;
        if (qsize(m) < DEPTH) qpush(m, d);
        @(negedge HCLK);
        s_valid[m] = 1'b0;
    endtask

    task automatic set_en(input int m, input logic v, input logic abandon);
        @(negedge HCLK);
        en[m] = v;
        if (!v) begin
            armed_m[m] = 1'b0;
            if (abandon) rx_live[m] = 1'b0;
        end
    endtask

    task automatic clear_und(input int m);
        @(negedge HCLK);
        clr[m] = 1'b1;
        @(negedge HCLK);
        clr[m] = 1'b0;
        und_m[m] = 1'b0;
        check($sformatf("clr_underrun%0d", m), und[m], 0);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 9; i++) begin
            vecs[i].data      = 16'h1000 + 16'(i * 16'h0111);
            vecs[i].exp_ready = (i < DEPTH);
            vecs[i].exp_level = (i < DEPTH) ? 4'(i + 1) : 4'(DEPTH);
        end

        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        for (int m = 0; m < 2; m++) begin
            check("rst_din", din[m], 0);
            check("rst_ready", rdy[m], 1);
            check("rst_level", lvl[m], 0);
            check("rst_underrun", und[m], 0);
        end

        // Stereo frame: A5C3 left, 0F0F right.
        push(0, 16'hA5C3);
        push(0, 16'h0F0F);
        set_en(0, 1'b1, 1'b0);
        run_slot(1'b1);
        run_slot(1'b0);
        run_slot(1'b1);
        set_en(0, 1'b0, 1'b0);

        // Mono: one pop per frame, sample replayed in the right slot.
        push(1, 16'h1234);
        set_en(1, 1'b1, 1'b0);
        check("mono_level_before", lvl[1], 1);
        run_slot(1'b0);
        check("stereo_no_underrun", und[0], 0);
        check("mono_level_after_left", lvl[1], 0);
        run_slot(1'b1);
        check("mono_level_after_right", lvl[1], 0);
        check("mono_no_underrun", und[1], 0);
        set_en(1, 1'b0, 1'b0);

        // Fill past full with BCLK idle.
        for (int i = 0; i < 9; i++) begin
            @(negedge HCLK);
            check("fill_ready", rdy[0], vecs[i].exp_ready);
            s_valid[0] = 1'b1;
            s_data[0] = vecs[i].data;
            if (vecs[i].exp_ready) qpush(0, vecs[i].data);
            @(negedge HCLK);
            s_valid[0] = 1'b0;
            check("fill_level", lvl[0], vecs[i].exp_level);
        end
        check("full_ready", rdy[0], 0);

        // Enable mid right slot, drain the FIFO, then underrun.
        run_slot(1'b0);
        repeat (5) bclk_bit(1'b1);
        set_en(0, 1'b1, 1'b0);
        repeat (SL - 5) bclk_bit(1'b1);
        for (int s = 0; s < 14; s++) run_slot((s % 2) == 1);
        set_en(0, 1'b0, 1'b0);
        check("drain_level", lvl[0], 0);
        check("underrun_set", und[0], 1);
        clear_und(0);

        // Reset mid-word with samples queued.
        push(0, 16'hFFFF);
        push(0, 16'h8001);
        push(0, 16'h7FFE);
        push(0, 16'h5555);
        set_en(0, 1'b1, 1'b0);
        repeat (10) bclk_bit(1'b0);
        check("pre_reset_din", din[0], 1);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check("reset_din", din[0], 0);
        check("reset_level", lvl[0], 0);
        check("reset_ready", rdy[0], 1);
        model_reset();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (SL - 10) bclk_bit(1'b0);
        run_slot(1'b1);
        run_slot(1'b0);
        check("post_reset_underrun", und[0], 1);

        // Disable mid-slot: DIN must drop at once.
        push(0, 16'hFFFF);
        repeat (4) bclk_bit(1'b1);
        check("pre_disable_din", din[0], 1);
        set_en(0, 1'b0, 1'b1);
        @(negedge HCLK);
        check("disable_din", din[0], 0);
        repeat (SL - 4) bclk_bit(1'b1);
        clear_und(0);

        // Randomised traffic on both instances.
        set_en(0, 1'b1, 1'b0);
        set_en(1, 1'b1, 1'b0);
        for (int it = 0; it < 25; it++) begin
            for (int m = 0; m < 2; m++) begin
                int n;
                n = $urandom_range(0, 4);
                for (int k = 0; k < n; k++) push(m, 16'($urandom));
            end
            begin
                int ns;
                ns = $urandom_range(1, 3);
                for (int s = 0; s < ns; s++) run_slot(!WS);
            end
            for (int m = 0; m < 2; m++) begin
                check("rand_level", lvl[m], qsize(m));
                check("rand_underrun", und[m], und_m[m]);
                if ($urandom_range(0, 3) == 0) clear_und(m);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_src_fifo.md
Name: i2s_src_fifo

Overview:
- Parametrised, synthesizable I2S slave transmitter that drives serial audio into the SoC's I2S receiver.
- The SoC is the bus master: it supplies the bit clock and word select; this block supplies the serial data line.
- Samples are buffered in an internal FIFO and shifted out MSB-first with the standard one-bit I2S delay.
- Used on-chip as a loopback audio source, and in benches as the next-generation replacement for the fixed-pattern I2S stimulus.

Parameters:
- SAMPLE_W, 16: bits per audio sample.
- SLOT_W, 32: BCLK periods per channel slot; must be >= SAMPLE_W. Bits after the sample LSB are driven 0.
- FIFO_DEPTH, 8: sample FIFO entries; must be a power of 2, >= 2.
- MONO, 0: 0 = stereo, one FIFO entry popped per channel slot. 1 = mono, one entry popped at the left slot and the same sample replayed in the right slot.

Ports:
- HCLK  in  1  system clock; all logic is in this domain.
- HRESETn  in  1  asynchronous active-low reset.
- en  in  1  transmit enable.
- BCLK  in  1  I2S bit clock from the SoC; asynchronous to HCLK.
- WS  in  1  I2S word select from the SoC. 0 = left slot, 1 = right slot.
- DIN  out  1  serial data to the SoC.
- s_data  in  SAMPLE_W  sample to push.
- s_valid  in  1  push request.
- s_ready  out  1  FIFO not full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun  out  1  sticky flag: a slot load found the FIFO empty.
- clr_underrun  in  1  clears underrun.

Behaviour:
- Reset values: DIN=0, s_ready=1, fifo_level=0, underrun=0. Shift register, slot bit counter and "armed" flag are cleared.
- Synchronisation:
  - BCLK and WS each pass through a 2-flop synchroniser into HCLK.
  - Edge detect on the synchronised BCLK produces one-cycle rise/fall event pulses.
  - Requirement: BCLK high and low phases are each >= 4 HCLK.
- WS sampling: WS is captured at each rise event into ws_r. The previous captured value is kept as ws_p.
- Fall event with ws_r != ws_p is a slot start (ws_p <= ws_r). The block:
  - Selects the slot word: left uses a FIFO pop; right uses a pop in stereo, or the held left sample in MONO.
  - Sets DIN <= word MSB, loads the shift register with word<<1, and sets the bit counter to 1.
  - This yields MSB at the first rise after the WS change plus one bit, i.e. the standard I2S delay.
- Any other fall event:
  - DIN <= shift MSB, shift <<= 1, bit counter increments, saturating at SLOT_W.
  - Zero fill comes from the shift-in.
  - An overlong slot (WS held past SLOT_W bits) keeps driving 0.
- Underrun: if a slot start needs a pop and the FIFO is empty, the word is all-zero, underrun sets, and no pop occurs.
- Enable and arming:
  - en low: DIN=0, no pops, armed=0. Pushes are still accepted.
  - After en rises, output begins at the first slot start that has WS=0 (left); armed=1 from then on. No partial-word start; right slots seen before arming are sent as 0 without popping.
- FIFO:
  - Push when s_valid && s_ready.
  - Simultaneous push and pop leaves the level unchanged; a push while full is ignored.
  - A push into an empty FIFO is visible to a pop on the next cycle, not the same cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- clr_underrun has priority over a same-cycle underrun set.
- en deasserted mid-slot: DIN forced 0 from the next HCLK edge; the remainder of the slot is discarded.
- Reset mid-frame: all state returns to reset values; the FIFO is emptied.

Optional Feature:
- Macro: I2S_SRC_FIFO_RAMP_EN.
- Defined: on underrun, instead of zero, the slot word is an internal per-channel SAMPLE_W ramp counter.
  - Counters reset to 0; left counter +1, right counter -1 per use, each wrapping.
  - underrun still sets.
- Undefined: underrun words are all-zero; no counter logic.

Test Plan:
- Reset, then push 0xA5C3 (left) and 0x0F0F (right), BCLK = 8 HCLK, SLOT_W=32, en=1 -> at the rises after each WS change, the SoC receives 0 then bits 1010010111000011 then 16 zeros for left; then 0x0F0F for right; underrun stays 0.
- MONO=1, push 0x1234 -> both slots of the frame carry 0x1234; fifo_level goes 1->0 exactly once per frame.
- FIFO_DEPTH=8: push 9 samples with no BCLK -> s_ready=0 after the 8th; the 9th is dropped; fifo_level=8.
- Run with an empty FIFO -> DIN stays 0 for the slot, underrun=1. clr_underrun pulse -> 0. With I2S_SRC_FIFO_RAMP_EN, left slots carry 0,1,2 and right slots 0,0xFFFF,0xFFFE.
- Raise en while WS=1 mid-slot -> DIN=0 until the next left slot start, which then carries the first FIFO sample.
- Assert HRESETn low mid-word with 3 entries queued -> DIN=0 and fifo_level=0 immediately; the next frame after release underruns.
